// File: rtl/sort4_pkg.sv
// rtl/sort4_pkg.sv - shared state encoding, sizes and compare-pair table for sort4_ctrl
package sort4_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int N      = 4;
    localparam int NSTEPS = 6;

    // Lower index j of the (j, j+1) pair compared at each step.
    function automatic logic [1:0] pair_idx(input logic [2:0] step);
        logic [1:0] j;
        j = 2'd0;
        case (step)
            3'd0: j = 2'd0;
            3'd1: j = 2'd1;
            3'd2: j = 2'd2;
            3'd3: j = 2'd0;
            3'd4: j = 2'd1;
            3'd5: j = 2'd0;
            default: j = 2'd0;
        endcase
        return j;
    endfunction

endpackage

// File: rtl/mag_cmp2.sv
// rtl/mag_cmp2.sv - combinational unsigned W-bit magnitude comparator
module mag_cmp2 #(
    parameter int W = 2
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gt,
    output logic         eq,
    output logic         lt
);

    assign gt = (a > b);
    assign eq = (a == b);
    assign lt = (a < b);

endmodule

// File: rtl/sort4_ctrl.sv
// rtl/sort4_ctrl.sv - four-element stable bubble sorter, one compare per cycle
module sort4_ctrl
    import sort4_pkg::*;
#(
    parameter int W = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [4*W-1:0] din,
    output logic [4*W-1:0] dout,
    output logic           busy,
    output logic           done,
    output logic [2:0]     swaps
);

    state_e         state_q, state_d;
    logic [2:0]     step_q, step_d;
    logic [2:0]     swaps_q, swaps_d;
    logic [W-1:0]   a_q [N];
    logic [W-1:0]   a_d [N];

    logic [1:0]     lo_idx;
    logic [1:0]     hi_idx;
    logic           cmp_gt;
    logic           cmp_eq_unused;
    logic           cmp_lt_unused;

    assign lo_idx = pair_idx(step_q);
    assign hi_idx = lo_idx + 2'd1;

    // Single comparator shared by every step; the pair is chosen by step_q.
    mag_cmp2 #(.W(W)) u_cmp (
        .a  (a_q[lo_idx]),
        .b  (a_q[hi_idx]),
        .gt (cmp_gt),
        .eq (cmp_eq_unused),
        .lt (cmp_lt_unused)
    );

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        swaps_d = swaps_q;
        for (int k = 0; k < N; k++) begin
            a_d[k] = a_q[k];
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int k = 0; k < N; k++) begin
                        a_d[k] = din[k*W +: W];
                    end
                    swaps_d = 3'd0;
                    step_d  = 3'd0;
                    state_d = SORT;
                end
            end
            SORT: begin
                // Strict greater-than only, so equal keys keep their order.
                if (cmp_gt) begin
                    a_d[lo_idx] = a_q[hi_idx];
                    a_d[hi_idx] = a_q[lo_idx];
                    if (swaps_q < 3'(NSTEPS)) begin
                        swaps_d = swaps_q + 3'd1;
                    end
                end
                if (step_q == 3'(NSTEPS - 1)) begin
                    state_d = DONE;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= 3'd0;
            swaps_q <= 3'd0;
            for (int k = 0; k < N; k++) begin
                a_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            swaps_q <= swaps_d;
            for (int k = 0; k < N; k++) begin
                a_q[k] <= a_d[k];
            end
        end
    end

    always_comb begin
        dout = '0;
        for (int k = 0; k < N; k++) begin
            dout[k*W +: W] = a_q[k];
        end
    end

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);
    assign swaps = swaps_q;

endmodule
